// File: rtl/bp_fe_bht_gshare.sv
// Gshare branch history table: saturating counters indexed by PC XOR global history,
// with a sequential init sweep and a one-cycle lookup pipeline.
module bp_fe_bht_gshare #(
  parameter int vaddr_width_p   = 39,
  parameter int bht_idx_width_p = 9,
  parameter int ghist_width_p   = 4,
  parameter int ctr_width_p     = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic                       init_done_o,
  input  logic                       r_v_i,
  input  logic [vaddr_width_p-1:0]   r_pc_i,
  output logic                       predict_v_o,
  output logic                       predict_o,
  output logic [bht_idx_width_p-1:0] predict_idx_o,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] w_idx_i,
  input  logic                       w_taken_i,
  output logic [ghist_width_p-1:0]   ghist_o
);

  localparam int els_lp = 1 << bht_idx_width_p;

  typedef logic [ctr_width_p-1:0] ctr_t;
  localparam ctr_t ctr_init_lp = ctr_t'((1 << (ctr_width_p - 1)) - 1);
  localparam ctr_t ctr_max_lp  = '1;

  typedef enum logic {
    e_init,
    e_ready
  } state_e;

  state_e                     state_r, state_n;
  logic [bht_idx_width_p-1:0] sweep_r;
  logic [ghist_width_p-1:0]   ghist_r;
  logic [ghist_width_p:0]     ghist_shift;
  logic [bht_idx_width_p-1:0] ghist_ext;
  logic [bht_idx_width_p-1:0] r_idx;
  logic                       predict_v_r;
  logic [bht_idx_width_p-1:0] predict_idx_r;
  logic                       ready, r_accept, w_accept;
  logic                       mem_we;
  logic [bht_idx_width_p-1:0] mem_waddr;
  ctr_t                       mem_wdata, w_ctr, w_ctr_n, pred_ctr;
  ctr_t                       mem_r [els_lp];
  logic                       unused_pc;

  assign ready    = (state_r == e_ready);
  assign r_accept = r_v_i & ready & ~reset_i;
  assign w_accept = w_v_i & ready & ~reset_i;

  // History is zero-extended at the MSBs before folding into the PC bits.
  assign ghist_ext = bht_idx_width_p'(ghist_r);
  assign r_idx     = r_pc_i[bht_idx_width_p+1:2] ^ ghist_ext;
  assign unused_pc = ^{r_pc_i[vaddr_width_p-1:bht_idx_width_p+2], r_pc_i[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_init;
    else         state_r <= state_n;
  end

  // NOTE: default assigned first so no path leaves state_n unassigned (no latch).
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_init:  if (sweep_r == '1) state_n = e_ready;
      e_ready: state_n = e_ready;
      default: state_n = e_init;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)              sweep_r <= '0;
    else if (state_r == e_init) sweep_r <= sweep_r + 1'b1;
  end

  // Saturating update of the counter being resolved.
  assign w_ctr = mem_r[w_idx_i];
  always_comb begin
    w_ctr_n = w_ctr;
    if (w_taken_i) begin
      if (w_ctr != ctr_max_lp) w_ctr_n = w_ctr + 1'b1;
    end else if (w_ctr != '0) begin
      w_ctr_n = w_ctr - 1'b1;
    end
  end

  assign mem_we    = ~reset_i & ((state_r == e_init) | w_accept);
  assign mem_waddr = (state_r == e_init) ? sweep_r : w_idx_i;
  assign mem_wdata = (state_r == e_init) ? ctr_init_lp : w_ctr_n;

  // NOTE: the counter array has no reset; the init sweep gives every entry its start value.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_r[mem_waddr] <= mem_wdata;
  end

  assign ghist_shift = {ghist_r, w_taken_i};
  always_ff @(posedge clk_i) begin
    if (reset_i)       ghist_r <= '0;
    else if (w_accept) ghist_r <= ghist_shift[ghist_width_p-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      predict_v_r   <= 1'b0;
      predict_idx_r <= '0;
    end else begin
      predict_v_r <= r_accept;
      if (r_accept) predict_idx_r <= r_idx;
    end
  end

  // The read follows the array write, so a write in the lookup cycle is seen here.
  assign pred_ctr      = mem_r[predict_idx_r];
  assign predict_o     = predict_v_r & pred_ctr[ctr_width_p-1];
  assign predict_v_o   = predict_v_r;
  assign predict_idx_o = predict_idx_r;
  assign init_done_o   = ready;
  assign ghist_o       = ghist_r;

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
// Scoreboard bench for bp_fe_bht_gshare: a reference counter table and history model
// produce expected outputs; lookups queue their index and are checked one cycle later.
module tb_bp_fe_bht_gshare;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        init_done_o;
  logic        r_v_i;
  logic [38:0] r_pc_i;
  logic        predict_v_o;
  logic        predict_o;
  logic [8:0]  predict_idx_o;
  logic        w_v_i;
  logic [8:0]  w_idx_i;
  logic        w_taken_i;
  logic [3:0]  ghist_o;

  bp_fe_bht_gshare #(
    .vaddr_width_p(39), .bht_idx_width_p(9), .ghist_width_p(4), .ctr_width_p(2)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .init_done_o(init_done_o),
    .r_v_i(r_v_i), .r_pc_i(r_pc_i),
    .predict_v_o(predict_v_o), .predict_o(predict_o), .predict_idx_o(predict_idx_o),
    .w_v_i(w_v_i), .w_idx_i(w_idx_i), .w_taken_i(w_taken_i),
    .ghist_o(ghist_o)
  );

  always #5 clk = ~clk;

  int       n_vec = 0;
  int       n_err = 0;
  int       mdl [512];
  logic [3:0] mghist = '0;
  bit       mready = 1'b0;
  int       msweep = 0;
  int       q_idx [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [38:0] pc_for(input logic [8:0] target);
    logic [38:0] p;
    p = {7'($urandom), $urandom};
    p[10:2] = target ^ {5'b0, mghist};
    return p;
  endfunction

  // Called at a negedge: check this cycle's outputs, drive this cycle's inputs,
  // advance the model by what commits at the coming posedge.
  task automatic step(input bit rst, input bit rv, input logic [38:0] pc,
                      input bit wv, input logic [8:0] widx, input bit wt);
    int i;
    check("init_done", {31'b0, init_done_o}, {31'b0, mready});
    check("ghist", {28'b0, ghist_o}, {28'b0, mghist});
    if (q_idx.size() > 0) begin
      i = q_idx.pop_front();
      check("predict_v", {31'b0, predict_v_o}, 32'd1);
      check("predict_idx", {23'b0, predict_idx_o}, i);
      check("predict", {31'b0, predict_o}, {31'b0, (mdl[i] >= 2)});
    end else begin
      check("predict_v_idle", {31'b0, predict_v_o}, 32'd0);
    end
    reset_i = rst; r_v_i = rv; r_pc_i = pc;
    w_v_i = wv; w_idx_i = widx; w_taken_i = wt;
    if (rst) begin
      mready = 1'b0; msweep = 0; mghist = '0; q_idx.delete();
    end else if (!mready) begin
      mdl[msweep] = 1;
      if (msweep == 511) mready = 1'b1;
      msweep++;
    end else begin
      if (rv) q_idx.push_back(int'(pc[10:2] ^ {5'b0, mghist}));
      if (wv) begin
        if (wt) begin
          if (mdl[widx] < 3) mdl[widx]++;
        end else if (mdl[widx] > 0) begin
          mdl[widx]--;
        end
        mghist = {mghist[2:0], wt};
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic lookup(input logic [8:0] target);
    step(1'b0, 1'b1, pc_for(target), 1'b0, '0, 1'b0);
  endtask

  task automatic update(input logic [8:0] idx, input bit taken);
    step(1'b0, 1'b0, '0, 1'b1, idx, taken);
  endtask

  initial begin
    reset_i = 1'b1; r_v_i = 1'b0; r_pc_i = '0;
    w_v_i = 1'b0; w_idx_i = '0; w_taken_i = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 39'h40, 1'b1, 9'd3, 1'b1);
    check("rst_predict_v", {31'b0, predict_v_o}, 32'd0);
    check("rst_predict", {31'b0, predict_o}, 32'd0);
    check("rst_predict_idx", {23'b0, predict_idx_o}, 32'd0);

    // Sweep interrupted after 7 writes; lookups and taken updates are dropped throughout.
    for (int c = 0; c < 7; c++) step(1'b0, 1'b1, pc_for(9'(c)), 1'b1, 9'(c), 1'b1);
    step(1'b1, 1'b1, pc_for(9'd0), 1'b1, 9'd0, 1'b1);
    check("midsweep_ghist", {28'b0, ghist_o}, 32'd0);
    for (int c = 0; c < 512; c++)
      step(1'b0, 1'b1, {7'($urandom), $urandom}, 1'b1, 9'($urandom), 1'b1);
    check("init_done_after_sweep", {31'b0, init_done_o}, 32'd1);
    check("init_ghist", {28'b0, ghist_o}, 32'd0);

    // Every entry must read back the weakly-not-taken init value.
    for (int e = 0; e < 512; e++) lookup(9'(e));
    idle();

    // Saturation on entry 7.
    repeat (4) update(9'd7, 1'b1);
    lookup(9'd7);
    check("sat_top", {31'b0, predict_o}, 32'd1);
    repeat (2) update(9'd7, 1'b0);
    lookup(9'd7);
    check("sat_down2", {31'b0, predict_o}, 32'd0);
    repeat (3) update(9'd7, 1'b0);
    lookup(9'd7);
    check("sat_floor", {31'b0, predict_o}, 32'd0);
    update(9'd7, 1'b1);
    lookup(9'd7);
    check("sat_no_wrap", {31'b0, predict_o}, 32'd0);
    update(9'd7, 1'b1);
    lookup(9'd7);
    check("sat_up2", {31'b0, predict_o}, 32'd1);

    // History folding into the index.
    update(9'd100, 1'b1);
    update(9'd100, 1'b1);
    update(9'd100, 1'b0);
    update(9'd100, 1'b1);
    step(1'b0, 1'b1, 39'h40, 1'b0, '0, 1'b0);
    check("hist_ghist", {28'b0, ghist_o}, 32'hD);
    check("hist_idx", {23'b0, predict_idx_o}, 32'h1D);
    idle();

    // Same-index collision on entry 5 (counter 1 -> 2).
    lookup(9'd5);
    check("coll_old", {31'b0, predict_o}, 32'd0);
    step(1'b0, 1'b1, pc_for(9'd5), 1'b1, 9'd5, 1'b1);
    check("coll_new", {31'b0, predict_o}, 32'd1);
    check("coll_new_idx", {23'b0, predict_idx_o}, 32'd5);
    idle();

    // Random traffic, including back-to-back lookups and concurrent updates.
    for (int c = 0; c < 400; c++)
      step(1'b0, 1'($urandom), {7'($urandom), $urandom},
           1'($urandom), 9'($urandom_range(0, 15)), 1'($urandom));
    idle();

    // Reset while in normal operation restarts the sweep.
    step(1'b1, 1'b1, pc_for(9'd1), 1'b1, 9'd1, 1'b1);
    check("oprst_predict_idx", {23'b0, predict_idx_o}, 32'd0);
    check("oprst_init_done", {31'b0, init_done_o}, 32'd0);
    for (int c = 0; c < 520; c++)
      step(1'b0, 1'($urandom), {7'($urandom), $urandom},
           1'($urandom), 9'($urandom), 1'($urandom));
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
